// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencing controller:
// state encoding, opcode values, datapath mux/ALU codes and helpers.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXEC_R    = 4'd6,
        ST_EXEC_I    = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JAL       = 4'd10,
        ST_JALR      = 4'd11,
        ST_UPPER     = 4'd12,
        ST_TRAP      = 4'd13
    } state_t;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // Load/store width funct3 values
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // ALU operand A source
    localparam logic [1:0] SEL_A_RS1    = 2'b00;
    localparam logic [1:0] SEL_A_PC     = 2'b01;
    localparam logic [1:0] SEL_A_OLD_PC = 2'b10;

    // ALU operand B source
    localparam logic [1:0] SEL_B_RS2  = 2'b00;
    localparam logic [1:0] SEL_B_IMM  = 2'b01;
    localparam logic [1:0] SEL_B_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_CMP   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // Register file write-back source
    localparam logic [2:0] RES_ALU    = 3'b000;
    localparam logic [2:0] RES_MEM    = 3'b001;
    localparam logic [2:0] RES_PC4    = 3'b010;
    localparam logic [2:0] RES_IMM    = 3'b011;
    localparam logic [2:0] RES_PC_IMM = 3'b100;

    // States that hold a request on the shared memory port
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_controller_memory_control_encoder.sv
// Maps load/store funct3 to the memory port control word
// {unsigned, half, byte, write} and flags widths RV32I does not define.
module memory_control_encoder
    import multicycle_controller_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       is_store_i,
    output logic [3:0] memory_control_o,
    output logic       width_legal_o
);

    // Width decode; unsigned variants exist only for loads
    always_comb begin
        memory_control_o = 4'b0000;
        width_legal_o    = 1'b0;
        case (funct3_i)
            F3_B: begin
                memory_control_o = {1'b0, 1'b0, 1'b1, is_store_i};
                width_legal_o    = 1'b1;
            end
            F3_H: begin
                memory_control_o = {1'b0, 1'b1, 1'b0, is_store_i};
                width_legal_o    = 1'b1;
            end
            F3_W: begin
                memory_control_o = {1'b0, 1'b0, 1'b0, is_store_i};
                width_legal_o    = 1'b1;
            end
            F3_BU: begin
                memory_control_o = is_store_i ? 4'b0000 : 4'b1010;
                width_legal_o    = ~is_store_i;
            end
            F3_HU: begin
                memory_control_o = is_store_i ? 4'b0000 : 4'b1100;
                width_legal_o    = ~is_store_i;
            end
            default: begin
                memory_control_o = 4'b0000;
                width_legal_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing controller for the multi-cycle RV32I core. A Moore FSM walks
// fetch/decode/execute/memory/writeback and drives every datapath strobe.
// The shared memory port uses valid/ready: a request is held (mem_valid=1,
// address and control stable) until the cycle mem_ready is seen high; that
// cycle completes the transfer. mem_ready with mem_valid low is ignored.
// A watchdog traps requests that wait TIMEOUT_CYCLES cycles without ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TIMEOUT_WIDTH  = 4,
    parameter bit ENABLE_TRAP    = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_valid,
    output logic       address_select,
    output logic [3:0] memory_control,
    output logic       instr_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] ALU_select_a,
    output logic [1:0] ALU_select_b,
    output logic [1:0] ALU_op,
    output logic [2:0] result_select,
    output logic       instr_retired,
    output logic       illegal,
    output logic       bus_error,
    output logic [3:0] debug_state
);

    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] WD_ONE  = TIMEOUT_WIDTH'(1);

    state_t                   state_q, state_d;
    logic [TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic                     illegal_q, illegal_d;
    logic                     bus_error_q, bus_error_d;

    logic       is_store;
    logic       width_legal;
    logic [3:0] enc_mc;
    logic       decode_illegal;
    state_t     dispatch;
    logic       wait_cycle;
    logic       timeout;

    assign is_store = (opcode == OPC_STORE);

    memory_control_encoder u_mc_enc (
        .funct3_i         (funct3),
        .is_store_i       (is_store),
        .memory_control_o (enc_mc),
        .width_legal_o    (width_legal)
    );

    // Opcode dispatch target and illegal-instruction detection for DECODE
    always_comb begin
        decode_illegal = 1'b0;
        dispatch       = ST_TRAP;
        case (opcode)
            OPC_LOAD, OPC_STORE: begin
                dispatch       = ST_MEM_ADDR;
                decode_illegal = ~width_legal;
            end
            OPC_OP:             dispatch = ST_EXEC_R;
            OPC_OP_IMM:         dispatch = ST_EXEC_I;
            OPC_BRANCH:         dispatch = ST_BRANCH;
            OPC_JAL:            dispatch = ST_JAL;
            OPC_JALR:           dispatch = ST_JALR;
            OPC_LUI, OPC_AUIPC: dispatch = ST_UPPER;
            default:            decode_illegal = 1'b1;
        endcase
    end

    // A wait cycle is an active request without ready. The counter is zero
    // whenever no wait is in progress, so every new request starts from 0.
    assign wait_cycle = is_mem_state(state_q) && !mem_ready;
    assign timeout    = ENABLE_TRAP && wait_cycle && (wd_q == WD_LAST);

    // Next-state, watchdog and sticky flag logic
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        wd_d        = (ENABLE_TRAP && wait_cycle) ? wd_q + WD_ONE : '0;
        case (state_q)
            ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!decode_illegal) begin
                    state_d = dispatch;
                end else if (ENABLE_TRAP) begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_MEM_ADDR:  state_d = is_store ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
            ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXEC_R,
            ST_EXEC_I:    state_d = ST_ALU_WB;
            ST_MEM_WB,
            ST_ALU_WB,
            ST_BRANCH,
            ST_JAL,
            ST_JALR,
            ST_UPPER:     state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_FETCH;
        endcase
        if (timeout) begin
            state_d     = ST_TRAP;
            bus_error_d = 1'b1;
        end
    end

    // State, watchdog and sticky trap flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            wd_q        <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_q        <= wd_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Strobe decode from state; forced quiet while reset is high so a request
    // in flight is dropped immediately and nothing is written
    always_comb begin
        mem_valid      = 1'b0;
        address_select = 1'b0;
        memory_control = 4'b0000;
        instr_write    = 1'b0;
        pc_write       = 1'b0;
        reg_write      = 1'b0;
        ALU_select_a   = SEL_A_RS1;
        ALU_select_b   = SEL_B_RS2;
        ALU_op         = ALU_ADD;
        result_select  = RES_ALU;
        instr_retired  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_valid    = 1'b1;
                    ALU_select_a = SEL_A_PC;
                    ALU_select_b = SEL_B_FOUR;
                    instr_write  = mem_ready;
                    pc_write     = mem_ready;
                end
                ST_DECODE: begin
                    ALU_select_a  = SEL_A_OLD_PC;
                    ALU_select_b  = SEL_B_IMM;
                    instr_retired = decode_illegal && !ENABLE_TRAP;
                end
                ST_MEM_ADDR: begin
                    ALU_select_b = SEL_B_IMM;
                end
                ST_MEM_READ: begin
                    mem_valid      = 1'b1;
                    address_select = 1'b1;
                    memory_control = enc_mc;
                end
                ST_MEM_WB: begin
                    reg_write     = 1'b1;
                    result_select = RES_MEM;
                    instr_retired = 1'b1;
                end
                ST_MEM_WRITE: begin
                    mem_valid      = 1'b1;
                    address_select = 1'b1;
                    memory_control = enc_mc;
                    instr_retired  = mem_ready;
                end
                ST_EXEC_R: begin
                    ALU_op = ALU_FUNCT;
                end
                ST_EXEC_I: begin
                    ALU_select_b = SEL_B_IMM;
                    ALU_op       = ALU_FUNCT;
                end
                ST_ALU_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                ST_BRANCH: begin
                    ALU_op        = ALU_CMP;
                    pc_write      = branch_taken;
                    instr_retired = 1'b1;
                end
                ST_JAL: begin
                    reg_write     = 1'b1;
                    result_select = RES_PC4;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                end
                ST_JALR: begin
                    ALU_select_b  = SEL_B_IMM;
                    reg_write     = 1'b1;
                    result_select = RES_PC4;
                    pc_write      = 1'b1;
                    instr_retired = 1'b1;
                end
                ST_UPPER: begin
                    reg_write     = 1'b1;
                    result_select = (opcode == OPC_LUI) ? RES_IMM : RES_PC_IMM;
                    instr_retired = 1'b1;
                end
                default: begin
                    mem_valid = 1'b0;
                end
            endcase
        end
    end

    assign illegal     = illegal_q;
    assign bus_error   = bus_error_q;
    assign debug_state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for the multi-cycle controller. Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 unit later, mid-cycle.
// Cycle 1 of an instruction is its first cycle in FETCH.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_valid, address_select, instr_write, pc_write, reg_write;
    logic [3:0] memory_control;
    logic [1:0] ALU_select_a, ALU_select_b, ALU_op;
    logic [2:0] result_select;
    logic       instr_retired, illegal, bus_error;
    logic [3:0] debug_state;

    int n_checks = 0;
    int n_fail   = 0;

    // Clock generation
    always #5 clock = ~clock;

    // Absolute simulation bound
    initial begin
        #500000;
        $display("FAIL sim_timeout: got no summary expected completion");
        $fatal(1);
    end

    multicycle_controller dut (
        .clock          (clock),
        .reset          (reset),
        .opcode         (opcode),
        .funct3         (funct3),
        .branch_taken   (branch_taken),
        .mem_ready      (mem_ready),
        .mem_valid      (mem_valid),
        .address_select (address_select),
        .memory_control (memory_control),
        .instr_write    (instr_write),
        .pc_write       (pc_write),
        .reg_write      (reg_write),
        .ALU_select_a   (ALU_select_a),
        .ALU_select_b   (ALU_select_b),
        .ALU_op         (ALU_op),
        .result_select  (result_select),
        .instr_retired  (instr_retired),
        .illegal        (illegal),
        .bus_error      (bus_error),
        .debug_state    (debug_state)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Reset pulse; returns at the input-drive point of FETCH cycle 1
    task automatic do_reset;
        tick;
        reset     = 1'b1;
        mem_ready = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    // Drives one instruction until instr_retired is seen. mem_ready is low in
    // cycles lo..hi and high otherwise. Returns at the retire sample point.
    task automatic run_to_retire(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic taken, input int lo, input int hi,
                                 output int cyc, output int rw_early,
                                 output int pcw_early, output int mem_cycles,
                                 output logic [3:0] mc_seen, output logic mc_changed);
        opcode       = opc;
        funct3       = f3;
        branch_taken = taken;
        cyc          = 1;
        rw_early     = 0;
        pcw_early    = 0;
        mem_cycles   = 0;
        mc_seen      = 4'd0;
        mc_changed   = 1'b0;
        mem_ready    = (cyc >= lo && cyc <= hi) ? 1'b0 : 1'b1;
        #1;
        while (instr_retired !== 1'b1 && cyc < 40) begin
            if (reg_write === 1'b1) rw_early++;
            if (cyc > 1 && pc_write === 1'b1) pcw_early++;
            if (mem_valid === 1'b1 && address_select === 1'b1) begin
                if (mem_cycles > 0 && memory_control !== mc_seen) mc_changed = 1'b1;
                mc_seen = memory_control;
                mem_cycles++;
            end
            tick;
            cyc++;
            mem_ready = (cyc >= lo && cyc <= hi) ? 1'b0 : 1'b1;
            #1;
        end
        if (mem_valid === 1'b1 && address_select === 1'b1) begin
            if (mem_cycles > 0 && memory_control !== mc_seen) mc_changed = 1'b1;
            mc_seen = memory_control;
            mem_cycles++;
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = OP_ALU;
        #1;
        n_checks++;
        if ({mem_valid, instr_write, pc_write, reg_write, instr_retired} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {mem_valid, instr_write, pc_write, reg_write, instr_retired});
        end
        n_checks++;
        if (debug_state !== ST_FETCH || illegal !== 1'b0 || bus_error !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got state %0d illegal %b bus_error %b expected 0 0 0",
                     debug_state, illegal, bus_error);
        end
        tick;
        mem_ready = 1'b0;
        reset     = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || address_select !== 1'b0 || instr_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got valid %b asel %b iw %b expected 1 0 0",
                     mem_valid, address_select, instr_write);
        end
    endtask

    task automatic test_add;
        int cyc, rw, pcw, mc_n;
        logic [3:0] mc;
        logic mc_chg;
        do_reset;
        run_to_retire(OP_ALU, 3'b000, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL add_latency: got %0d expected 4", cyc);
        end
        n_checks++;
        if (reg_write !== 1'b1 || result_select !== 3'b000 || rw !== 0 || pcw !== 0) begin
            n_fail++;
            $display("FAIL add_writeback: got rw %b res %b early_rw %0d early_pcw %0d expected 1 000 0 0",
                     reg_write, result_select, rw, pcw);
        end
        tick;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (reg_write !== 1'b0 || mem_valid !== 1'b1 || instr_write !== 1'b1) begin
            n_fail++;
            $display("FAIL add_next_fetch: got rw %b valid %b iw %b expected 0 1 1",
                     reg_write, mem_valid, instr_write);
        end
    endtask

    task automatic test_lbu_wait;
        int cyc, rw, pcw, mc_n;
        logic [3:0] mc;
        logic mc_chg;
        do_reset;
        run_to_retire(OP_LOAD, 3'b100, 1'b0, 4, 6, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 8) begin
            n_fail++;
            $display("FAIL lbu_latency: got %0d expected 8", cyc);
        end
        n_checks++;
        if (mc !== 4'b1010 || mc_chg !== 1'b0 || mc_n !== 4) begin
            n_fail++;
            $display("FAIL lbu_request: got mc %b changed %b cycles %0d expected 1010 0 4",
                     mc, mc_chg, mc_n);
        end
        n_checks++;
        if (reg_write !== 1'b1 || result_select !== 3'b001 || rw !== 0) begin
            n_fail++;
            $display("FAIL lbu_writeback: got rw %b res %b early_rw %0d expected 1 001 0",
                     reg_write, result_select, rw);
        end
    endtask

    task automatic test_store;
        int cyc, rw, pcw, mc_n;
        logic [3:0] mc;
        logic mc_chg;
        do_reset;
        run_to_retire(OP_STORE, 3'b010, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 4 || mc !== 4'b0001 || mc_n !== 1 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_zero_wait: got cyc %0d mc %b cycles %0d rw %b expected 4 0001 1 0",
                     cyc, mc, mc_n, reg_write);
        end
        tick;
        run_to_retire(OP_STORE, 3'b001, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 4 || mc !== 4'b0101) begin
            n_fail++;
            $display("FAIL sh_zero_wait: got cyc %0d mc %b expected 4 0101", cyc, mc);
        end
        // 14 wait cycles is one short of the watchdog limit
        tick;
        run_to_retire(OP_STORE, 3'b000, 1'b0, 4, 17, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 18 || bus_error !== 1'b0 || mc !== 4'b0011) begin
            n_fail++;
            $display("FAIL sb_near_timeout: got cyc %0d bus_error %b mc %b expected 18 0 0011",
                     cyc, bus_error, mc);
        end
    endtask

    task automatic test_branch_jump;
        int cyc, rw, pcw, mc_n;
        logic [3:0] mc;
        logic mc_chg;
        do_reset;
        run_to_retire(OP_BRANCH, 3'b000, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 3 || pc_write !== 1'b0 || pcw !== 0 || reg_write !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_not_taken: got cyc %0d pcw %b early_pcw %0d rw %b expected 3 0 0 0",
                     cyc, pc_write, pcw, reg_write);
        end
        tick;
        run_to_retire(OP_BRANCH, 3'b000, 1'b1, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 3 || pc_write !== 1'b1 || ALU_op !== 2'b01) begin
            n_fail++;
            $display("FAIL beq_taken: got cyc %0d pcw %b aluop %b expected 3 1 01",
                     cyc, pc_write, ALU_op);
        end
        tick;
        run_to_retire(OP_JAL, 3'b000, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 3 || pc_write !== 1'b1 || reg_write !== 1'b1 || result_select !== 3'b010) begin
            n_fail++;
            $display("FAIL jal: got cyc %0d pcw %b rw %b res %b expected 3 1 1 010",
                     cyc, pc_write, reg_write, result_select);
        end
        tick;
        run_to_retire(OP_LUI, 3'b000, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (reg_write !== 1'b1 || result_select !== 3'b011) begin
            n_fail++;
            $display("FAIL lui: got rw %b res %b expected 1 011", reg_write, result_select);
        end
        tick;
        run_to_retire(OP_AUIPC, 3'b000, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (reg_write !== 1'b1 || result_select !== 3'b100) begin
            n_fail++;
            $display("FAIL auipc: got rw %b res %b expected 1 100", reg_write, result_select);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, rw, pcw, mc_n;
        logic [3:0] mc;
        logic mc_chg;
        do_reset;
        // Fetch stalls for two cycles, then the add completes
        run_to_retire(OP_ALU, 3'b000, 1'b0, 1, 2, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 6 || pcw !== 1) begin
            n_fail++;
            $display("FAIL fetch_stall: got cyc %0d pc_updates %0d expected 6 1", cyc, pcw);
        end
        tick;
        run_to_retire(OP_LOAD, 3'b010, 1'b0, 0, 0, cyc, rw, pcw, mc_n, mc, mc_chg);
        n_checks++;
        if (cyc !== 5 || mc !== 4'b0000) begin
            n_fail++;
            $display("FAIL lw_back_to_back: got cyc %0d mc %b expected 5 0000", cyc, mc);
        end
    endtask

    task automatic test_illegal;
        int bad;
        do_reset;
        opcode    = OP_BAD;
        funct3    = 3'b000;
        mem_ready = 1'b1;
        tick;
        tick;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (reg_write !== 1'b0 || pc_write !== 1'b0 || instr_retired !== 1'b0 ||
                mem_valid !== 1'b0) bad++;
            tick;
        end
        #1;
        n_checks++;
        if (bad !== 0 || illegal !== 1'b1 || debug_state !== ST_TRAP) begin
            n_fail++;
            $display("FAIL illegal_opcode: got strobe_cycles %0d illegal %b state %0d expected 0 1 %0d",
                     bad, illegal, debug_state, ST_TRAP);
        end
        do_reset;
        mem_ready = 1'b0;
        #1;
        n_checks++;
        if (illegal !== 1'b0 || mem_valid !== 1'b1 || debug_state !== ST_FETCH) begin
            n_fail++;
            $display("FAIL illegal_reset: got illegal %b valid %b state %0d expected 0 1 0",
                     illegal, mem_valid, debug_state);
        end
        do_reset;
        opcode    = OP_LOAD;
        funct3    = 3'b011;
        mem_ready = 1'b1;
        tick;
        tick;
        #1;
        n_checks++;
        if (illegal !== 1'b1 || debug_state !== ST_TRAP) begin
            n_fail++;
            $display("FAIL illegal_load_f3: got illegal %b state %0d expected 1 %0d",
                     illegal, debug_state, ST_TRAP);
        end
        do_reset;
        opcode    = OP_STORE;
        funct3    = 3'b100;
        mem_ready = 1'b1;
        tick;
        tick;
        #1;
        n_checks++;
        if (illegal !== 1'b1 || debug_state !== ST_TRAP) begin
            n_fail++;
            $display("FAIL illegal_store_f3: got illegal %b state %0d expected 1 %0d",
                     illegal, debug_state, ST_TRAP);
        end
    endtask

    task automatic test_timeout;
        int cyc, waits;
        do_reset;
        opcode       = OP_STORE;
        funct3       = 3'b010;
        mem_ready    = 1'b1;
        cyc          = 1;
        waits        = 0;
        #1;
        while (bus_error !== 1'b1 && cyc < 40) begin
            if (mem_valid === 1'b1 && address_select === 1'b1 && mem_ready === 1'b0) waits++;
            tick;
            cyc++;
            mem_ready = 1'b0;
            #1;
        end
        n_checks++;
        if (cyc !== 19 || waits !== 15) begin
            n_fail++;
            $display("FAIL timeout_timing: got cyc %0d waits %0d expected 19 15", cyc, waits);
        end
        n_checks++;
        if (mem_valid !== 1'b0 || debug_state !== ST_TRAP || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_trap: got valid %b state %0d illegal %b expected 0 %0d 0",
                     mem_valid, debug_state, illegal, ST_TRAP);
        end
        tick;
        tick;
        mem_ready = 1'b1;
        #1;
        n_checks++;
        if (bus_error !== 1'b1 || mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_sticky: got bus_error %b valid %b expected 1 0", bus_error, mem_valid);
        end
    endtask

    task automatic test_reset_mid_read;
        do_reset;
        opcode    = OP_LOAD;
        funct3    = 3'b010;
        mem_ready = 1'b1;
        tick;
        tick;
        tick;
        mem_ready = 1'b0;
        tick;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || address_select !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_read_active: got valid %b asel %b expected 1 1", mem_valid, address_select);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({mem_valid, reg_write, pc_write, instr_write} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_read_reset: got %b expected 0000",
                     {mem_valid, reg_write, pc_write, instr_write});
        end
        tick;
        reset = 1'b0;
        #1;
        n_checks++;
        if (mem_valid !== 1'b1 || address_select !== 1'b0 || debug_state !== ST_FETCH) begin
            n_fail++;
            $display("FAIL mid_read_release: got valid %b asel %b state %0d expected 1 0 0",
                     mem_valid, address_select, debug_state);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_lbu_wait;
        test_store;
        test_branch_jump;
        test_back_to_back;
        test_illegal;
        test_timeout;
        test_reset_mid_read;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
